// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, logic/shift/move/arith ALU and HI/LO registers.
// Define EX_DIV_EN to build in the multi-cycle restoring divider (DIV/DIVU) and its stall request.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  id_aluop_i,
   input  logic [2:0]  id_alusel_i,
   input  logic [31:0] id_reg1_i,
   input  logic [31:0] id_reg2_i,
   input  logic [4:0]  id_wd_i,
   input  logic        id_wreg_i,
   output logic [4:0]  ex_wd_o,
   output logic        ex_wreg_o,
   output logic [31:0] ex_wdata_o,
   output logic        stallreq_o
);

   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MFLO = 8'h12;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_reg1;
   logic [31:0] ex_reg2;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        is_div;
   logic [31:0] logic_res;
   logic [31:0] shift_res;
   logic [31:0] move_res;
   logic [31:0] arith_res;

   // ID/EX register holds its instruction while the divider asks for a stall
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_aluop  <= 8'h00;
         ex_alusel <= 3'b000;
         ex_reg1   <= 32'h0;
         ex_reg2   <= 32'h0;
         ex_wd     <= 5'd0;
         ex_wreg   <= 1'b0;
      end else if (!stallreq_o) begin
         ex_aluop  <= id_aluop_i;
         ex_alusel <= id_alusel_i;
         ex_reg1   <= id_reg1_i;
         ex_reg2   <= id_reg2_i;
         ex_wd     <= id_wd_i;
         ex_wreg   <= id_wreg_i;
      end
   end

   assign is_div = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);

   always_comb begin
      logic_res = 32'h0;
      shift_res = 32'h0;
      move_res  = 32'h0;
      arith_res = 32'h0;
      case (ex_aluop)
         OP_OR:   logic_res = ex_reg1 | ex_reg2;
         OP_AND:  logic_res = ex_reg1 & ex_reg2;
         OP_XOR:  logic_res = ex_reg1 ^ ex_reg2;
         OP_NOR:  logic_res = ~(ex_reg1 | ex_reg2);
         OP_SLL:  shift_res = ex_reg2 << ex_reg1[4:0];
         OP_SRL:  shift_res = ex_reg2 >> ex_reg1[4:0];
         OP_SRA:  shift_res = $signed(ex_reg2) >>> ex_reg1[4:0];
         OP_MFHI: move_res  = hi;
         OP_MFLO: move_res  = lo;
         OP_ADDU: arith_res = ex_reg1 + ex_reg2;
         OP_SUBU: arith_res = ex_reg1 - ex_reg2;
         OP_SLT:  arith_res = ($signed(ex_reg1) < $signed(ex_reg2)) ? 32'd1 : 32'd0;
         default: ;
      endcase
   end

   // An opcode paired with the wrong result group yields zero rather than garbage
   always_comb begin
      ex_wdata_o = 32'h0;
      case (ex_alusel)
         SEL_LOGIC: ex_wdata_o = logic_res;
         SEL_SHIFT: ex_wdata_o = shift_res;
         SEL_MOVE:  ex_wdata_o = move_res;
         SEL_ARITH: ex_wdata_o = arith_res;
         default:   ex_wdata_o = 32'h0;
      endcase
   end

   assign ex_wd_o   = ex_wd;
   assign ex_wreg_o = ex_wreg && !is_div;

`ifdef EX_DIV_EN
   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

   div_state_t  state;
   logic [4:0]  count;
   logic [31:0] divisor;
   logic [31:0] rem;
   logic [31:0] quo;
   logic        neg_q;
   logic        neg_r;
   logic        dividend_neg;
   logic        divisor_neg;
   logic [32:0] trial;

   assign dividend_neg = (ex_aluop == OP_DIV) && ex_reg1[31];
   assign divisor_neg  = (ex_aluop == OP_DIV) && ex_reg2[31];
   assign trial        = {rem, quo[31]} - {1'b0, divisor};

   // Stall must be raised in the same cycle the DIV reaches EX so the following instruction waits in ID
   assign stallreq_o = ((state == IDLE) && is_div) || (state == RUN);

   // Restoring divider on magnitudes; quo doubles as the dividend shift register, signs fixed up in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= 5'd0;
         divisor <= 32'h0;
         rem     <= 32'h0;
         quo     <= 32'h0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         hi      <= 32'h0;
         lo      <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (is_div) begin
                  if (ex_reg2 == 32'h0) begin
                     quo   <= 32'hFFFF_FFFF;
                     rem   <= ex_reg1;
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
                     state <= DONE;
                  end else begin
                     quo     <= dividend_neg ? -ex_reg1 : ex_reg1;
                     divisor <= divisor_neg ? -ex_reg2 : ex_reg2;
                     rem     <= 32'h0;
                     neg_q   <= dividend_neg ^ divisor_neg;
                     neg_r   <= dividend_neg;
                     count   <= 5'd0;
                     state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (!trial[32]) begin
                  rem <= trial[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= {rem[30:0], quo[31]};
                  quo <= {quo[30:0], 1'b0};
               end
               count <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= DONE;
               end
            end
            DONE: begin
               lo    <= neg_q ? -quo : quo;
               hi    <= neg_r ? -rem : rem;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign stallreq_o = 1'b0;

   // Without the divider HI/LO only ever hold their reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end
   end
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus randomized ALU traffic against a behavioural model.
// Division expectations follow whether EX_DIV_EN is defined for the build.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  id_aluop_i;
   logic [2:0]  id_alusel_i;
   logic [31:0] id_reg1_i;
   logic [31:0] id_reg2_i;
   logic [4:0]  id_wd_i;
   logic        id_wreg_i;
   logic [4:0]  ex_wd_o;
   logic        ex_wreg_o;
   logic [31:0] ex_wdata_o;
   logic        stallreq_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_hi = 32'h0;
   logic [31:0] model_lo = 32'h0;

   logic [7:0] op_tab  [12] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                8'h21, 8'h23, 8'h2A, 8'h10, 8'h12};
   logic [2:0] sel_tab [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                                3'd4, 3'd4, 3'd4, 3'd3, 3'd3};

   ex_stage dut (
      .clk         (clk),
      .rst         (rst),
      .id_aluop_i  (id_aluop_i),
      .id_alusel_i (id_alusel_i),
      .id_reg1_i   (id_reg1_i),
      .id_reg2_i   (id_reg2_i),
      .id_wd_i     (id_wd_i),
      .id_wreg_i   (id_wreg_i),
      .ex_wd_o     (ex_wd_o),
      .ex_wreg_o   (ex_wreg_o),
      .ex_wdata_o  (ex_wdata_o),
      .stallreq_o  (stallreq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit is_defined(input logic [7:0] op);
      for (int i = 0; i < 12; i++) if (op_tab[i] == op) return 1'b1;
      return (op == 8'h00) || (op == 8'h1A) || (op == 8'h1B);
   endfunction

   // Result first by opcode meaning, then kept only if the selector names that opcode's group
   function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [2:0] sel,
                                               input logic [31:0] a, input logic [31:0] b);
      logic [31:0] res;
      int grp;
      res = 32'h0;
      grp = 0;
      case (op)
         8'h25: begin res = a | b;    grp = 1; end
         8'h24: begin res = a & b;    grp = 1; end
         8'h26: begin res = a ^ b;    grp = 1; end
         8'h27: begin res = ~(a | b); grp = 1; end
         8'h7C: begin res = b * (32'd1 << (a % 32)); grp = 2; end
         8'h02: begin res = b / (33'd1 << (a % 32)); grp = 2; end
         8'h03: begin res = 32'($signed(b) >>> (a % 32)); grp = 2; end
         8'h10: begin res = model_hi; grp = 3; end
         8'h12: begin res = model_lo; grp = 3; end
         8'h21: begin res = a + b; grp = 4; end
         8'h23: begin res = a - b; grp = 4; end
         8'h2A: begin res = (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0; grp = 4; end
         default: ;
      endcase
      return (grp != 0 && int'(sel) == grp) ? res : 32'h0;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] wd, input logic wreg);
      id_aluop_i  = op;
      id_alusel_i = sel;
      id_reg1_i   = a;
      id_reg2_i   = b;
      id_wd_i     = wd;
      id_wreg_i   = wreg;
      @(posedge clk);
      #1;
   endtask

   task automatic checkInstr(input string tag, input logic [7:0] op, input logic [2:0] sel,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                             input logic wreg);
      applyStimulus(op, sel, a, b, wd, wreg);
      checkOutput({tag, "_wdata"}, ex_wdata_o, model_wdata(op, sel, a, b));
      checkOutput({tag, "_wd"}, 32'(ex_wd_o), 32'(wd));
      checkOutput({tag, "_wreg"}, 32'(ex_wreg_o), 32'(wreg && op != 8'h1A && op != 8'h1B));
      checkOutput({tag, "_stall"}, 32'(stallreq_o), 32'd0);
   endtask

`ifdef EX_DIV_EN
   task automatic runDivide(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      int stall_cnt;
      int wreg_seen;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (op == 8'h1B) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = 32'(int'($signed(a)) / int'($signed(b)));
         r = 32'(int'($signed(a)) % int'($signed(b)));
      end
      applyStimulus(op, 3'b000, a, b, 5'd7, 1'b1);
      id_aluop_i  = 8'h12;
      id_alusel_i = 3'b011;
      id_wd_i     = 5'd8;
      stall_cnt   = 0;
      wreg_seen   = 0;
      while (stallreq_o === 1'b1 && stall_cnt < 200) begin
         if (ex_wreg_o !== 1'b0) wreg_seen++;
         stall_cnt++;
         @(posedge clk);
         #1;
      end
      checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), (b == 32'h0) ? 32'd1 : 32'd33);
      checkOutput({tag, "_wreg_in_stall"}, 32'(wreg_seen), 32'd0);
      checkOutput({tag, "_wreg_done"}, 32'(ex_wreg_o), 32'd0);
      model_lo = q;
      model_hi = r;
      checkInstr({tag, "_mflo"}, 8'h12, 3'b011, $urandom, $urandom, 5'd8, 1'b1);
      checkInstr({tag, "_mfhi"}, 8'h10, 3'b011, $urandom, $urandom, 5'd9, 1'b1);
   endtask
`endif

   initial begin
      rst = 1'b1;
      applyStimulus(8'h25, 3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b1);
      applyStimulus(8'h25, 3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 1'b1);
      checkOutput("reset_wdata", ex_wdata_o, 32'h0);
      checkOutput("reset_wd", 32'(ex_wd_o), 32'h0);
      checkOutput("reset_wreg", 32'(ex_wreg_o), 32'h0);
      checkOutput("reset_stall", 32'(stallreq_o), 32'h0);
      rst = 1'b0;
      checkInstr("reset_mflo", 8'h12, 3'b011, 32'h0, 32'h0, 5'd1, 1'b1);
      checkInstr("reset_mfhi", 8'h10, 3'b011, 32'h0, 32'h0, 5'd1, 1'b1);

      checkInstr("ori", 8'h25, 3'b001, 32'h0000_1100, 32'h0000_FF00, 5'd3, 1'b1);
      checkOutput("ori_literal", ex_wdata_o, 32'h0000_FF00);
      checkInstr("sra", 8'h03, 3'b010, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
      checkOutput("sra_literal", ex_wdata_o, 32'hF800_0000);
      checkInstr("slt", 8'h2A, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
      checkOutput("slt_literal", ex_wdata_o, 32'd1);
      checkInstr("subu", 8'h23, 3'b100, 32'd0, 32'd1, 5'd6, 1'b1);
      checkOutput("subu_literal", ex_wdata_o, 32'hFFFF_FFFF);
      checkInstr("bad_sel", 8'h21, 3'b111, 32'd5, 32'd6, 5'd7, 1'b1);
      checkInstr("nop", 8'h00, 3'b000, 32'd5, 32'd6, 5'd0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         int k;
         logic [7:0] op;
         logic [2:0] sel;
         k   = $urandom_range(0, 11);
         op  = op_tab[k];
         sel = sel_tab[k];
         if ($urandom_range(0, 9) == 0) sel = 3'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            op = 8'($urandom);
            while (is_defined(op)) op = 8'($urandom);
         end
         checkInstr("rand", op, sel, pick_operand(), pick_operand(), 5'($urandom), 1'($urandom));
      end

`ifdef EX_DIV_EN
      runDivide("div_neg7_2", 8'h1A, 32'hFFFF_FFF9, 32'd2);
      checkOutput("div_neg7_2_hi_literal", ex_wdata_o, 32'hFFFF_FFFF);
      runDivide("divu_by_zero", 8'h1B, 32'd100, 32'd0);
      checkOutput("divu_by_zero_hi_literal", ex_wdata_o, 32'd100);
      runDivide("div_minint", 8'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         runDivide("div_rand", ($urandom_range(0, 1) == 1) ? 8'h1A : 8'h1B, pick_operand(),
                   ($urandom_range(0, 4) == 0) ? 32'h0 : pick_operand());
      end

      applyStimulus(8'h1B, 3'b000, 32'd50, 32'd7, 5'd2, 1'b1);
      id_aluop_i  = 8'h12;
      id_alusel_i = 3'b011;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort_running", 32'(stallreq_o), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_stall", 32'(stallreq_o), 32'd0);
      checkOutput("abort_wdata", ex_wdata_o, 32'h0);
      checkOutput("abort_wd", 32'(ex_wd_o), 32'h0);
      checkOutput("abort_wreg", 32'(ex_wreg_o), 32'h0);
      model_hi = 32'h0;
      model_lo = 32'h0;
      checkInstr("abort_mflo", 8'h12, 3'b011, 32'h0, 32'h0, 5'd8, 1'b1);
      checkInstr("abort_mfhi", 8'h10, 3'b011, 32'h0, 32'h0, 5'd9, 1'b1);
`else
      checkInstr("nodiv_divu", 8'h1B, 3'b000, 32'd50, 32'd7, 5'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkInstr("nodiv_after", 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
      end
      checkInstr("nodiv_div", 8'h1A, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
      checkInstr("nodiv_mflo", 8'h12, 3'b011, 32'h0, 32'h0, 5'd8, 1'b1);
      checkInstr("nodiv_mfhi", 8'h10, 3'b011, 32'h0, 32'h0, 5'd9, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
